// File: rtl/usb_bulk_uart_ep_if.sv
`default_nettype none
// ============================================================================
// Module      : usb_bulk_uart_ep_if
// Description : Signal bundle between the bulk UART endpoint bridge, the
//               protocol engine's bulk OUT/IN endpoint slots and the UART
//               byte-stream pipelines.
//               master : the endpoint bridge (drives req/get/put/done, the
//                        UART OUT stream and the UART IN ready)
//               slave  : protocol engine + UART pipelines
// Ports       : out_ep_*  bulk OUT endpoint buffer access (host -> device)
//               in_ep_*   bulk IN endpoint buffer access (device -> host)
//               uart_in_* stream toward the host (valid/ready)
//               uart_out_* stream from the host (valid/ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_bulk_uart_ep_if;
    // OUT endpoint
    logic       out_ep_req;
    logic       out_ep_grant;
    logic       out_ep_data_avail;
    logic       out_ep_setup;
    logic       out_ep_data_get;
    logic [7:0] out_ep_data;
    logic       out_ep_stall;
    logic       out_ep_acked;
    // IN endpoint
    logic       in_ep_req;
    logic       in_ep_grant;
    logic       in_ep_data_free;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;
    logic       in_ep_stall;
    logic       in_ep_acked;
    // UART streams
    logic [7:0] uart_in_data;
    logic       uart_in_valid;
    logic       uart_in_ready;
    logic [7:0] uart_out_data;
    logic       uart_out_valid;
    logic       uart_out_ready;

    modport master (
        output out_ep_req, out_ep_data_get, out_ep_stall,
        input  out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
        output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
        input  in_ep_grant, in_ep_data_free, in_ep_acked,
        input  uart_in_data, uart_in_valid,
        output uart_in_ready,
        output uart_out_data, uart_out_valid,
        input  uart_out_ready
    );

    modport slave (
        input  out_ep_req, out_ep_data_get, out_ep_stall,
        output out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
        input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
        output in_ep_grant, in_ep_data_free, in_ep_acked,
        output uart_in_data, uart_in_valid,
        input  uart_in_ready,
        input  uart_out_data, uart_out_valid,
        output uart_out_ready
    );
endinterface
`default_nettype wire

// File: rtl/usb_bulk_uart_ep.sv
`default_nettype none
// ============================================================================
// Module      : usb_bulk_uart_ep
// Description : Bulk endpoint bridge for the USB serial core. The OUT path
//               reads host bytes from the bulk OUT buffer one at a time and
//               offers them as a valid/ready stream. The IN path packs the
//               incoming stream into IN packets, closing a packet when it
//               holds MAX_PACKET bytes or when no byte has arrived for
//               FLUSH_CYCLES clocks.
// Ports       : clk   - 48 MHz system clock
//               reset - synchronous active-high reset
//               bus   - endpoint/stream bundle (master side)
// Parameters  : MAX_PACKET   - IN packet byte limit (1..64)
//               FLUSH_CYCLES - idle clocks before a short packet closes (>=2)
// Revision    : 1.0 - initial release
// ============================================================================
module usb_bulk_uart_ep #(
    parameter int MAX_PACKET   = 32,
    parameter int FLUSH_CYCLES = 48000
) (
    input  logic               clk,
    input  logic               reset,
    usb_bulk_uart_ep_if.master bus
);

    localparam int c_CNT_W = $clog2(MAX_PACKET + 1);
    localparam int c_TMR_W = $clog2(FLUSH_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_PACKET - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(FLUSH_CYCLES - 1);

    // ------------------------------------------------------------------
    // OUT path: endpoint buffer -> uart_out stream
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_GET  = 2'd1,
        O_WAIT = 2'd2
    } out_state_t;

    out_state_t out_state_q, out_state_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q,  out_data_d;
    logic       w_out_get;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_state_q <= O_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        w_out_get   = 1'b0;

        // Held byte leaves on the consumer handshake.
        if (out_valid_q && bus.uart_out_ready) begin
            out_valid_d = 1'b0;
        end

        case (out_state_q)
            O_IDLE: begin
                if (bus.out_ep_data_avail) begin
                    out_state_d = O_GET;
                end
            end
            O_GET: begin
                if (!bus.out_ep_data_avail) begin
                    out_state_d = O_IDLE;
                end else if (bus.out_ep_grant && (!out_valid_q || bus.uart_out_ready)) begin
                    // Only fetch when the holding register is free or emptying now.
                    w_out_get   = 1'b1;
                    out_state_d = O_WAIT;
                end
            end
            O_WAIT: begin
                // Byte returned by the buffer this cycle; keep it only if the
                // consumer does not take it right away.
                out_data_d  = bus.out_ep_data;
                out_valid_d = !bus.uart_out_ready;
                out_state_d = bus.out_ep_data_avail ? O_GET : O_IDLE;
            end
            default: begin
                out_state_d = O_IDLE;
            end
        endcase
    end

    assign bus.out_ep_req      = (out_state_q != O_IDLE);
    assign bus.out_ep_data_get = w_out_get;
    assign bus.out_ep_stall    = 1'b0;
    // In O_WAIT the fetched byte is forwarded straight from the buffer so it
    // reaches the consumer the cycle after the get; the holding register
    // cannot be occupied then because the get required it to be draining.
    assign bus.uart_out_valid  = out_valid_q | (out_state_q == O_WAIT);
    assign bus.uart_out_data   = (out_state_q == O_WAIT) ? bus.out_ep_data : out_data_q;

    // ------------------------------------------------------------------
    // IN path: uart_in stream -> endpoint buffer, packetised
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_FILL = 2'd1,
        I_DONE = 2'd2,
        I_ACK  = 2'd3
    } in_state_t;

    in_state_t          in_state_q, in_state_d;
    logic [c_CNT_W-1:0] in_cnt_q,   in_cnt_d;
    logic [c_TMR_W-1:0] in_tmr_q,   in_tmr_d;
    logic               w_in_ready;
    logic               w_in_hs;
    logic               w_in_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_q <= I_IDLE;
            in_cnt_q   <= '0;
            in_tmr_q   <= '0;
        end else begin
            in_state_q <= in_state_d;
            in_cnt_q   <= in_cnt_d;
            in_tmr_q   <= in_tmr_d;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        in_cnt_d   = in_cnt_q;
        in_tmr_d   = in_tmr_q;
        w_in_ready = 1'b0;
        w_in_hs    = 1'b0;
        w_in_done  = 1'b0;

        case (in_state_q)
            I_IDLE: begin
                in_cnt_d = '0;
                in_tmr_d = '0;
                if (bus.uart_in_valid) begin
                    in_state_d = I_FILL;
                end
            end
            I_FILL: begin
                w_in_ready = bus.in_ep_grant && bus.in_ep_data_free;
                w_in_hs    = w_in_ready && bus.uart_in_valid;
                if (w_in_hs) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    in_tmr_d = '0;
                    if (in_cnt_q == c_CNT_LAST) begin
                        in_state_d = I_DONE;
                    end
                end else begin
                    // Idle timer runs even without grant; it saturates so a
                    // long stall cannot wrap it back below the flush point.
                    if (in_tmr_q != c_TMR_LAST) begin
                        in_tmr_d = in_tmr_q + 1'b1;
                    end
                    if ((in_cnt_q != '0) && (in_tmr_q == c_TMR_LAST)) begin
                        in_state_d = I_DONE;
                    end
                end
            end
            I_DONE: begin
                // Packet close is only signalled while we own the buffer.
                w_in_done = bus.in_ep_grant;
                if (bus.in_ep_grant) begin
                    in_state_d = I_ACK;
                end
            end
            I_ACK: begin
                if (bus.in_ep_acked) begin
                    in_state_d = I_IDLE;
                end
            end
            default: begin
                in_state_d = I_IDLE;
            end
        endcase
    end

    assign bus.in_ep_req       = (in_state_q != I_IDLE);
    assign bus.in_ep_data_put  = w_in_hs;
    assign bus.in_ep_data      = w_in_hs ? bus.uart_in_data : 8'h00;
    assign bus.in_ep_data_done = w_in_done;
    assign bus.in_ep_stall     = 1'b0;
    assign bus.uart_in_ready   = w_in_ready;

    // SETUP and OUT-ack carry no meaning for a bulk data endpoint.
    logic w_unused;
    assign w_unused = &{1'b0, bus.out_ep_setup, bus.out_ep_acked};

endmodule
`default_nettype wire

// File: tb/tb_usb_bulk_uart_ep.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_bulk_uart_ep
// Description : Self-checking bench for usb_bulk_uart_ep. A vector table
//               covers reset and single-cycle IN handshake behaviour; a small
//               per-cycle engine/UART model drives the multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_bulk_uart_ep;

    localparam int c_MAX   = 32;
    localparam int c_FLUSH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    usb_bulk_uart_ep_if bus ();

    usb_bulk_uart_ep #(
        .MAX_PACKET   (c_MAX),
        .FLUSH_CYCLES (c_FLUSH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       grant;
        logic       free;
        logic       acked;
        logic       e_req;
        logic       e_ready;
        logic       e_put;
        logic [7:0] e_data;
        logic       e_done;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic rst, input logic valid, input logic [7:0] data,
                                input logic grant, input logic free, input logic acked,
                                input logic e_req, input logic e_ready, input logic e_put,
                                input logic [7:0] e_data, input logic e_done);
        vec_t v;
        v.rst = rst; v.valid = valid; v.data = data; v.grant = grant; v.free = free;
        v.acked = acked; v.e_req = e_req; v.e_ready = e_ready; v.e_put = e_put;
        v.e_data = e_data; v.e_done = e_done;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Model state
    // ------------------------------------------------------------------
    logic [7:0] out_buf[$];
    logic [7:0] out_exp[$];
    logic [7:0] in_src[$];
    logic [7:0] in_exp[$];
    int         get_cyc[$];
    int         pkt_sizes[$];
    int cyc = 0, last_get = -100, last_put = -100, first_put = -1;
    int n_gets = 0, n_puts = 0, n_done = 0, pkt_cnt = 0;
    int ack_cnt = 0, ack_delay = 0;
    logic auto_ack = 1'b0, in_wait_ack = 1'b0, in_en = 1'b0;
    logic prev_valid = 1'b0, prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic tick();
        logic do_pop;
        logic do_hs;
        do_pop = 1'b0;
        do_hs  = 1'b0;
        @(negedge clk);
        // OUT path observation
        if (bus.out_ep_data_get) begin
            check("get_with_data", int'(out_buf.size() > 0), 1);
            check("get_spacing", int'(cyc - last_get >= 2), 1);
            last_get = cyc;
            get_cyc.push_back(cyc);
            n_gets++;
            do_pop = 1'b1;
        end
        if (bus.uart_out_valid && !prev_valid) check("out_latency", cyc - last_get, 1);
        if (prev_stall) begin
            check("out_hold_valid", int'(bus.uart_out_valid), 1);
            check("out_hold_data", int'(bus.uart_out_data), int'(prev_data));
        end
        if (bus.uart_out_valid && bus.uart_out_ready) begin
            if (out_exp.size() == 0) check("out_unexpected", 1, 0);
            else check("out_byte", int'(bus.uart_out_data), int'(out_exp.pop_front()));
        end
        prev_valid = bus.uart_out_valid;
        prev_stall = bus.uart_out_valid && !bus.uart_out_ready;
        prev_data  = bus.uart_out_data;
        // IN path observation
        if (bus.uart_in_ready)
            check("ready_needs_grant_free", int'(bus.in_ep_grant && bus.in_ep_data_free), 1);
        if (bus.in_ep_data_put) begin
            check("put_is_handshake", int'(bus.uart_in_valid && bus.uart_in_ready), 1);
            if (in_exp.size() == 0) check("in_unexpected", 1, 0);
            else check("in_byte", int'(bus.in_ep_data), int'(in_exp.pop_front()));
            pkt_cnt++;
            check("pkt_limit", int'(pkt_cnt <= c_MAX), 1);
            if (n_puts == 0 || first_put < 0) first_put = cyc;
            last_put = cyc;
            n_puts++;
            do_hs = 1'b1;
        end
        if (bus.in_ep_data_done || in_wait_ack)
            check("ready_low_after_close", int'(bus.uart_in_ready), 0);
        if (bus.in_ep_data_done) begin
            check("done_has_grant", int'(bus.in_ep_grant), 1);
            check("done_nonempty", int'(pkt_cnt > 0), 1);
            if (pkt_cnt == c_MAX) check("done_full_at", cyc - last_put, 1);
            else check("done_flush_at", cyc - last_put, c_FLUSH + 1);
            pkt_sizes.push_back(pkt_cnt);
            pkt_cnt     = 0;
            n_done++;
            in_wait_ack = 1'b1;
            ack_cnt     = ack_delay;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (do_pop && out_buf.size() > 0) bus.out_ep_data = out_buf.pop_front();
        bus.out_ep_data_avail = (out_buf.size() > 0);
        if (do_hs && in_src.size() > 0) void'(in_src.pop_front());
        bus.in_ep_acked = 1'b0;
        if (in_wait_ack && auto_ack) begin
            if (ack_cnt == 0) begin
                bus.in_ep_acked = 1'b1;
                in_wait_ack     = 1'b0;
            end else begin
                ack_cnt--;
            end
        end
        bus.uart_in_valid = in_en && (in_src.size() > 0);
        bus.uart_in_data  = (in_src.size() > 0) ? in_src[0] : 8'h00;
    endtask

    initial begin
        int gets0;
        int puts0;
        int done0;

        // ---------------- vector table ----------------
        //            rst  vld  data   gnt  free ack   req  rdy  put  edata  done
        vecs[0]  = mk(1'b1,1'b1,8'hA5,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0);
        vecs[1]  = mk(1'b1,1'b1,8'hA5,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0);
        vecs[2]  = mk(1'b1,1'b1,8'hA5,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0);
        vecs[3]  = mk(1'b0,1'b1,8'hA5,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0);
        vecs[4]  = mk(1'b0,1'b1,8'hA5,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,8'hA5,1'b0);
        vecs[5]  = mk(1'b0,1'b1,8'h3C,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0);
        vecs[6]  = mk(1'b0,1'b1,8'h3C,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h00,1'b0);
        vecs[7]  = mk(1'b0,1'b1,8'h3C,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b1,8'h3C,1'b0);
        vecs[8]  = mk(1'b0,1'b0,8'h00,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,8'h00,1'b0);
        vecs[9]  = mk(1'b1,1'b0,8'h00,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b0);
        vecs[10] = mk(1'b0,1'b0,8'h00,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,8'h00,1'b0);
        vecs[11] = mk(1'b0,1'b0,8'h00,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,8'h00,1'b0);

        bus.out_ep_grant      = 1'b0;
        bus.out_ep_data_avail = 1'b0;
        bus.out_ep_setup      = 1'b0;
        bus.out_ep_data       = 8'h00;
        bus.out_ep_acked      = 1'b0;
        bus.uart_out_ready    = 1'b0;

        for (int i = 0; i < 12; i++) begin
            reset               = vecs[i].rst;
            bus.uart_in_valid   = vecs[i].valid;
            bus.uart_in_data    = vecs[i].data;
            bus.in_ep_grant     = vecs[i].grant;
            bus.in_ep_data_free = vecs[i].free;
            bus.in_ep_acked     = vecs[i].acked;
            @(negedge clk);
            check($sformatf("v%0d_in_req", i),   int'(bus.in_ep_req),       int'(vecs[i].e_req));
            check($sformatf("v%0d_in_ready", i), int'(bus.uart_in_ready),   int'(vecs[i].e_ready));
            check($sformatf("v%0d_put", i),      int'(bus.in_ep_data_put),  int'(vecs[i].e_put));
            check($sformatf("v%0d_in_data", i),  int'(bus.in_ep_data),      int'(vecs[i].e_data));
            check($sformatf("v%0d_done", i),     int'(bus.in_ep_data_done), int'(vecs[i].e_done));
            check($sformatf("v%0d_out_quiet", i),
                  int'({bus.out_ep_req, bus.out_ep_data_get, bus.uart_out_valid}), 0);
            check($sformatf("v%0d_out_data", i), int'(bus.uart_out_data), 0);
            check($sformatf("v%0d_stalls", i),   int'({bus.out_ep_stall, bus.in_ep_stall}), 0);
            @(posedge clk);
            #1;
        end

        // Partial packet discarded by reset: its flush point passes silently.
        bus.in_ep_acked = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_discard_no_done", int'(bus.in_ep_data_done), 0);
            check("reset_discard_idle", int'(bus.in_ep_req), 0);
            @(posedge clk);
            #1;
        end

        // ---------------- OUT: 5 bytes, consumer always ready ----------------
        for (int i = 0; i < 5; i++) begin
            out_buf.push_back(8'(8'h10 + i));
            out_exp.push_back(8'(8'h10 + i));
        end
        bus.out_ep_data_avail = 1'b1;
        bus.out_ep_grant      = 1'b1;
        bus.uart_out_ready    = 1'b1;
        get_cyc.delete();
        gets0 = n_gets;
        for (int k = 0; k < 40; k++) begin
            if (out_exp.size() == 0 && !bus.out_ep_req) break;
            tick();
        end
        check("outA_finished", int'(out_exp.size() == 0 && !bus.out_ep_req), 1);
        check("outA_gets", n_gets - gets0, 5);
        for (int i = 1; i < get_cyc.size(); i++)
            check("outA_get_gap", get_cyc[i] - get_cyc[i-1], 2);
        check("outA_req_low", int'(bus.out_ep_req), 0);

        // ---------------- OUT: consumer backpressure ----------------
        for (int i = 0; i < 3; i++) begin
            out_buf.push_back(8'(8'h20 + i));
            out_exp.push_back(8'(8'h20 + i));
        end
        bus.out_ep_data_avail = 1'b1;
        bus.uart_out_ready    = 1'b0;
        gets0 = n_gets;
        repeat (20) tick();
        check("outB_single_get", n_gets - gets0, 1);
        check("outB_valid_held", int'(bus.uart_out_valid), 1);
        check("outB_data_held", int'(bus.uart_out_data), 8'h20);
        bus.uart_out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (out_exp.size() == 0 && !bus.out_ep_req) break;
            tick();
        end
        check("outB_drained", int'(out_exp.size() == 0 && !bus.out_ep_req), 1);
        check("outB_gets", n_gets - gets0, 3);

        // ---------------- IN: full packet of 32 bytes ----------------
        for (int i = 0; i <= c_MAX; i++) begin
            in_src.push_back(8'(i));
            in_exp.push_back(8'(i));
        end
        in_en    = 1'b1;
        auto_ack = 1'b0;
        bus.in_ep_grant     = 1'b1;
        bus.in_ep_data_free = 1'b1;
        bus.uart_in_valid   = 1'b1;
        bus.uart_in_data    = in_src[0];
        puts0 = n_puts; done0 = n_done; first_put = -1;
        for (int k = 0; k < 60; k++) begin
            if (n_done != done0) break;
            tick();
        end
        check("inC_closed", n_done - done0, 1);
        check("inC_puts", n_puts - puts0, c_MAX);
        check("inC_consecutive", last_put - first_put, c_MAX - 1);
        repeat (5) tick();
        check("inC_no_put_before_ack", n_puts - puts0, c_MAX);
        check("inC_req_held", int'(bus.in_ep_req), 1);

        // ---------------- IN: flush after 3 bytes ----------------
        // Byte 0x20 is already waiting; it opens the next packet after the ack.
        in_src.push_back(8'h21); in_exp.push_back(8'h21);
        in_src.push_back(8'h22); in_exp.push_back(8'h22);
        auto_ack = 1'b1;
        ack_cnt  = 0;
        done0    = n_done;
        for (int k = 0; k < 60; k++) begin
            if (n_done != done0) break;
            tick();
        end
        check("inD_closed", n_done - done0, 1);
        check("inD_pkt_size", pkt_sizes[pkt_sizes.size()-1], 3);
        in_src.push_back(8'h55); in_exp.push_back(8'h55);
        done0 = n_done;
        for (int k = 0; k < 60; k++) begin
            if (n_done != done0) break;
            tick();
        end
        check("inD_single_closed", n_done - done0, 1);
        check("inD_single_size", pkt_sizes[pkt_sizes.size()-1], 1);
        for (int k = 0; k < 10; k++) begin
            if (!bus.in_ep_req && !in_wait_ack) break;
            tick();
        end
        check("inD_released", int'(bus.in_ep_req), 0);

        // ---------------- concurrent OUT and IN traffic ----------------
        for (int i = 0; i < 12; i++) begin
            out_buf.push_back(8'(8'h80 + i));
            out_exp.push_back(8'(8'h80 + i));
        end
        for (int i = 0; i < 40; i++) begin
            in_src.push_back(8'(8'h40 + i));
            in_exp.push_back(8'(8'h40 + i));
        end
        bus.out_ep_data_avail = 1'b1;
        ack_delay = 3;
        done0 = n_done;
        for (int k = 0; k < 400; k++) begin
            if (in_exp.size() == 0 && out_exp.size() == 0 && n_done == done0 + 2 &&
                !bus.in_ep_req && !bus.out_ep_req) break;
            bus.in_ep_data_free = ((cyc / 4) % 2) == 0;
            bus.uart_out_ready  = (cyc % 3) != 0;
            tick();
        end
        check("inE_all_in", in_exp.size(), 0);
        check("inE_all_out", out_exp.size(), 0);
        check("inE_packets", n_done - done0, 2);
        check("inE_pkt0", pkt_sizes[pkt_sizes.size()-2], c_MAX);
        check("inE_pkt1", pkt_sizes[pkt_sizes.size()-1], 8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_bulk_uart_ep.md
# usb_bulk_uart_ep

Bulk-endpoint bridge between the full-speed protocol engine's endpoint interfaces and the byte-stream UART pipelines of the USB serial core. It owns one bulk OUT endpoint (host → device) and one bulk IN endpoint (device → host). It is instantiated beside the serial control endpoint and wired to the second slot of the protocol engine's OUT and IN endpoint arrays. OUT packet bytes are delivered as a valid/ready stream. Incoming stream bytes are packed into IN packets and closed on size or on idle timeout.

## Interface
Parameters:
- MAX_PACKET, 32 — IN packet byte limit; also the bulk wMaxPacketSize (1..64).
- FLUSH_CYCLES, 48000 — idle clk cycles after the last accepted byte before a short IN packet is closed (1 ms at 48 MHz); must be ≥2.

Ports:
- clk  in  1  48 MHz system clock
- reset  in  1  synchronous, active-high reset
- out_ep_req  out  1  request OUT buffer access
- out_ep_grant  in  1  OUT buffer access granted
- out_ep_data_avail  in  1  unread byte(s) present in OUT buffer
- out_ep_setup  in  1  SETUP flag (ignored; bulk endpoint)
- out_ep_data_get  out  1  read strobe, one byte per cycle asserted
- out_ep_data  in  8  byte returned one cycle after data_get
- out_ep_stall  out  1  constant 0
- out_ep_acked  in  1  OUT packet acked (unused)
- in_ep_req  out  1  request IN buffer access
- in_ep_grant  in  1  IN buffer access granted
- in_ep_data_free  in  1  IN buffer can accept a byte
- in_ep_data_put  out  1  write strobe for in_ep_data
- in_ep_data  out  8  byte written when data_put high
- in_ep_data_done  out  1  one-cycle pulse: IN packet complete
- in_ep_stall  out  1  constant 0
- in_ep_acked  in  1  host acked the IN packet
- uart_in_data  in  8  stream byte toward host
- uart_in_valid  in  1  uart_in_data valid
- uart_in_ready  out  1  byte accepted when valid && ready
- uart_out_data  out  8  byte from host
- uart_out_valid  out  1  uart_out_data valid
- uart_out_ready  in  1  consumer accepts when valid && ready

## Operation
OUT path, states O_IDLE, O_GET, O_WAIT:
- O_IDLE: out_ep_req=0.
  - On out_ep_data_avail, set out_ep_req=1 and move to O_GET.
- O_GET, while out_ep_grant=1: assert out_ep_data_get for one cycle only if all of these hold: data_avail=1, no byte in flight, and the output holding register is empty or being drained this cycle. Then move to O_WAIT.
- O_WAIT: capture out_ep_data into the uart_out_data register and set uart_out_valid=1.
  - Return to O_GET if data_avail is still 1.
  - Otherwise drop out_ep_req and return to O_IDLE.
- At most one byte in flight. uart_out_data stays stable while valid && !ready.

IN path, states I_IDLE, I_FILL, I_DONE, I_ACK:
- I_IDLE: on uart_in_valid, set in_ep_req=1 and move to I_FILL. The byte count and idle timer are cleared.
- I_FILL, with in_ep_grant=1 and in_ep_data_free=1:
  - uart_in_ready=1.
  - On a handshake, in_ep_data_put=1 and in_ep_data=uart_in_data in the same cycle, count+1, and the timer is cleared.
  - uart_in_ready=0 whenever grant or data_free is low.
- Packet close conditions, in I_FILL:
  - count reaches MAX_PACKET: move to I_DONE.
  - count≥1 and the timer reaches FLUSH_CYCLES−1 with no handshake: move to I_DONE.
- I_DONE: in_ep_data_done pulses for one cycle, then move to I_ACK.
- I_ACK: in_ep_req stays high and uart_in_ready=0.
  - On in_ep_acked, drop in_ep_req and move to I_IDLE.
- No zero-length packet is generated after a full packet.
- Count is a $clog2(MAX_PACKET+1)-bit counter. Timer is a $clog2(FLUSH_CYCLES)-bit counter that saturates.

The OUT and IN paths are independent and may be active in the same cycle.

## Timing
- Reset values: out_ep_req=0, out_ep_data_get=0, uart_out_valid=0, uart_out_data=0, in_ep_req=0, in_ep_data_put=0, in_ep_data=0, in_ep_data_done=0, uart_in_ready=0, both stalls=0. Both FSMs are in IDLE.
- Reset mid-packet discards the partial packet and any held OUT byte, with no data_done.
- OUT latency: data_get in cycle N gives uart_out_valid=1 in cycle N+1.
  - Peak rate is 1 byte per 2 cycles.
  - Back-to-back gets are forbidden.
- IN: data_put is combinational with the handshake (same cycle), giving 1 byte/cycle peak.
  - The MAX_PACKET-th put is followed by in_ep_data_done in the next cycle.
  - For the timeout, data_done asserts FLUSH_CYCLES+1 cycles after the last put.
- Loss of grant mid-packet pauses IN filling without closing the packet. The timer keeps running and may close the packet, in which case data_done waits for grant.
- in_ep_acked outside I_ACK is ignored.

## Test plan
- Reset: hold reset 3 cycles with uart_in_valid=1 → all outputs at reset values, no put or get.
- OUT: 5 bytes 0x10..0x14 available, grant=1, uart_out_ready=1 → 5 gets spaced 2 cycles apart, uart_out sequence 0x10..0x14, then out_ep_req=0.
- OUT backpressure: uart_out_ready=0 for 20 cycles with 3 bytes pending → exactly 1 get, uart_out_data stable; the remainder drains in order after ready=1.
- IN full packet: 32 consecutive bytes 0x00..0x1F with grant=1 and data_free=1 → 32 puts on consecutive cycles, data_done 1 cycle after the last put, uart_in_ready=0 until acked.
- IN flush: 3 bytes then idle, FLUSH_CYCLES=16 → data_done 17 cycles after the 3rd put; after in_ep_acked, a new byte restarts with count=1.
- Concurrency: simultaneous OUT and IN traffic with data_free toggling every 4 cycles → no byte lost or duplicated on either path; packet boundaries as specified.
